// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry.  The fetch stage looks up fetch_pc combinationally.  The execute
// stage reports resolved conditional branches.  Those reports train the table
// and raise a one-cycle registered redirect when the carried-down prediction
// was wrong.
//
// Parameters
//   WIDTH    PC / datapath width in bits
//   ENTRIES  table depth (power of two, >= 2)
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-high reset
//   fetch_pc         PC being fetched this cycle
//   pred_taken       predicted direction for fetch_pc (combinational)
//   pred_target      predicted next PC for fetch_pc (combinational)
//   res_valid        a conditional branch resolves this cycle
//   res_pc           PC of the resolving branch
//   res_taken        actual branch outcome
//   res_target       computed branch target
//   res_pred_taken   prediction that travelled down the pipe with the branch
//   res_pred_target  predicted target that travelled with the branch
//   redirect_valid   one-cycle mispredict pulse (registered)
//   redirect_pc      corrected fetch PC (registered, holds between pulses)
// ----------------------------------------------------------------------------
module branch_predictor #(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fetch_pc,
   output logic             pred_taken,
   output logic [WIDTH-1:0] pred_target,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_pc,
   input  logic             res_taken,
   input  logic [WIDTH-1:0] res_target,
   input  logic             res_pred_taken,
   input  logic [WIDTH-1:0] res_pred_target,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = WIDTH - IDX - 2;

   // ------------------------------------------------------------------------
   // Table state.  valid and the counters reset; tag and target do not need
   // to, because a cleared valid bit masks them.
   // ------------------------------------------------------------------------
   logic [ENTRIES-1:0] valid_reg;
   logic [ENTRIES-1:0] valid_next;
   logic [1:0]         ctr_reg    [ENTRIES];
   logic [1:0]         ctr_next   [ENTRIES];
   logic [TAG_W-1:0]   tag_reg    [ENTRIES];
   logic [WIDTH-1:0]   target_reg [ENTRIES];

   logic             redirect_valid_reg;
   logic             redirect_valid_next;
   logic [WIDTH-1:0] redirect_pc_reg;
   logic [WIDTH-1:0] redirect_pc_next;

   // Address split.  PC[1:0] never selects anything.
   logic [IDX-1:0]   fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic [IDX-1:0]   res_idx;
   logic [TAG_W-1:0] res_tag;
   logic             unused_low_bits;

   assign fetch_idx       = fetch_pc[IDX+1:2];
   assign fetch_tag       = fetch_pc[WIDTH-1:IDX+2];
   assign res_idx         = res_pc[IDX+1:2];
   assign res_tag         = res_pc[WIDTH-1:IDX+2];
   assign unused_low_bits = ^{fetch_pc[1:0], res_pc[1:0]};

   // ------------------------------------------------------------------------
   // Fetch-side lookup.  This path reads the registered table only, so an
   // update to the same index in the same cycle is not visible until the
   // next cycle.
   // ------------------------------------------------------------------------
   logic fetch_hit;

   assign fetch_hit   = valid_reg[fetch_idx] && (tag_reg[fetch_idx] == fetch_tag);
   assign pred_taken  = fetch_hit && ctr_reg[fetch_idx][1];
   assign pred_target = pred_taken ? target_reg[fetch_idx]
                                   : fetch_pc + WIDTH'(4);

   // ------------------------------------------------------------------------
   // Resolve-side update decision
   // ------------------------------------------------------------------------
   logic       res_hit;
   logic       ctr_we;     // counter / valid write at res_idx
   logic       entry_we;   // tag + target write at res_idx
   logic [1:0] res_ctr;
   logic [1:0] ctr_upd;

   assign res_hit = valid_reg[res_idx] && (tag_reg[res_idx] == res_tag);
   assign res_ctr = ctr_reg[res_idx];

   // A hit trains the counter in either direction.  A taken miss
   // (including a taken alias) takes the slot over.  A not-taken miss
   // leaves the table alone.
   assign ctr_we   = res_valid && (res_hit || res_taken);
   assign entry_we = res_valid && res_taken;

   always_comb begin
      ctr_upd = 2'b10;   // weakly taken for a freshly allocated entry
      if (res_hit) begin
         if (res_taken) begin
            ctr_upd = (res_ctr == 2'b11) ? 2'b11 : res_ctr + 2'd1;
         end else begin
            ctr_upd = (res_ctr == 2'b00) ? 2'b00 : res_ctr - 2'd1;
         end
      end
   end

   // Per-entry next state.  Only the entry addressed by res_idx can change.
   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic sel;
         assign sel            = ctr_we && (res_idx == IDX'(gi));
         assign ctr_next[gi]   = sel ? ctr_upd : ctr_reg[gi];
         // An allocation sets valid.  A hit is already valid.
         assign valid_next[gi] = valid_reg[gi] | (sel & res_taken);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Mispredict detection.  A correct not-taken prediction never compares
   // targets, because the fall-through path was already fetched.
   // ------------------------------------------------------------------------
   logic mispredict;

   assign mispredict = res_valid &&
                       ((res_taken != res_pred_taken) ||
                        (res_taken && (res_pred_target != res_target)));

   always_comb begin
      redirect_valid_next = mispredict;
      redirect_pc_next    = redirect_pc_reg;
      if (mispredict) begin
         redirect_pc_next = res_taken ? res_target : res_pc + WIDTH'(4);
      end
   end

   // ------------------------------------------------------------------------
   // Resettable state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg          <= '0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_reg[i] <= 2'b01;
         end
      end else begin
         valid_reg          <= valid_next;
         redirect_valid_reg <= redirect_valid_next;
         redirect_pc_reg    <= redirect_pc_next;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_reg[i] <= ctr_next[i];
         end
      end
   end

   // Tag and target storage is not reset.  An edge that arrives while rst is
   // still high must not write, so any update from that cycle is dropped
   // together with the cleared valid bits.
   always_ff @(posedge clk) begin
      if (!rst && entry_we) begin
         tag_reg[res_idx]    <= res_tag;
         target_reg[res_idx] <= res_target;
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//
// Each resolve cycle pushes its expected registered redirect into a queue.
// The monitor pops that entry and compares it one time unit after the next
// rising edge.  Combinational predictions are checked inline by each scenario
// task.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

   localparam int WIDTH   = 32;
   localparam int ENTRIES = 16;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] fetch_pc;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_target;
   logic             res_valid;
   logic [WIDTH-1:0] res_pc;
   logic             res_taken;
   logic [WIDTH-1:0] res_target;
   logic             res_pred_taken;
   logic [WIDTH-1:0] res_pred_target;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             rv;
      logic [WIDTH-1:0] rpc;
      string            name;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   branch_predictor #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_pc        (fetch_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .res_valid       (res_valid),
      .res_pc          (res_pc),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .res_pred_taken  (res_pred_taken),
      .res_pred_target (res_pred_target),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor for the registered redirect outputs
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         sb_e = sb_q.pop_front();
         checks++;
         if (redirect_valid !== sb_e.rv || redirect_pc !== sb_e.rpc) begin
            errors++;
            $display("FAIL %s: redirect_valid=%0b redirect_pc=%08h expected %0b %08h",
                     sb_e.name, redirect_valid, redirect_pc, sb_e.rv, sb_e.rpc);
         end else begin
            $display("ok   %s: redirect_valid=%0b redirect_pc=%08h",
                     sb_e.name, redirect_valid, redirect_pc);
         end
      end
   end

   // One resolve cycle.  The expected redirect is queued before the edge.
   task automatic step(input string nm, input logic v, input logic [WIDTH-1:0] pc,
                       input logic tk, input logic [WIDTH-1:0] tgt,
                       input logic ptk, input logic [WIDTH-1:0] ptgt,
                       input logic erv, input logic [WIDTH-1:0] erpc);
      exp_t e;
      res_valid       = v;
      res_pc          = pc;
      res_taken       = tk;
      res_target      = tgt;
      res_pred_taken  = ptk;
      res_pred_target = ptgt;
      e.rv   = erv;
      e.rpc  = erpc;
      e.name = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
      res_pred_taken = 1'b0; res_pred_target = '0;
      fetch_pc = 32'h100;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         errors++;
         $display("FAIL reset_pred: %0b %08h expected 0 00000104", pred_taken, pred_target);
      end else $display("ok   reset_pred");
      checks++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_redirect: %0b %08h expected 0 00000000", redirect_valid, redirect_pc);
      end else $display("ok   reset_redirect");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_allocate();
      step("alloc_mispredict", 1, 32'h100, 1, 32'h200, 0, 32'h104, 1, 32'h200);
      step("alloc_pulse_end", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h200);
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         errors++;
         $display("FAIL alloc_pred: %0b %08h expected 1 00000200", pred_taken, pred_target);
      end else $display("ok   alloc_pred");
   endtask

   task automatic test_counter();
      step("ctr_up1", 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 32'h200);
      step("ctr_up2", 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 32'h200);
      step("ctr_dn1", 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h104);
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         errors++;
         $display("FAIL ctr_after_one_nt: %0b %08h expected 1 00000200", pred_taken, pred_target);
      end else $display("ok   ctr_after_one_nt");
      step("ctr_dn2", 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h104);
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         errors++;
         $display("FAIL ctr_after_two_nt: %0b %08h expected 0 00000104", pred_taken, pred_target);
      end else $display("ok   ctr_after_two_nt");
   endtask

   task automatic test_alias();
      step("alias_retrain", 1, 32'h100, 1, 32'h200, 0, 32'h104, 1, 32'h200);
      fetch_pc = 32'h140; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
         errors++;
         $display("FAIL alias_miss: %0b %08h expected 0 00000144", pred_taken, pred_target);
      end else $display("ok   alias_miss");
      step("alias_nt", 1, 32'h140, 0, 32'h500, 0, 32'h144, 0, 32'h200);
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         errors++;
         $display("FAIL alias_nt_keeps: %0b %08h expected 1 00000200", pred_taken, pred_target);
      end else $display("ok   alias_nt_keeps");
      step("alias_take", 1, 32'h140, 1, 32'h300, 0, 32'h144, 1, 32'h300);
      fetch_pc = 32'h140; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
         errors++;
         $display("FAIL alias_new: %0b %08h expected 1 00000300", pred_taken, pred_target);
      end else $display("ok   alias_new");
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         errors++;
         $display("FAIL alias_evicted: %0b %08h expected 0 00000104", pred_taken, pred_target);
      end else $display("ok   alias_evicted");
   endtask

   task automatic test_redirect();
      step("correct_taken", 1, 32'h140, 1, 32'h300, 1, 32'h300, 0, 32'h300);
      step("target_mismatch", 1, 32'h140, 1, 32'h380, 1, 32'h300, 1, 32'h380);
      step("nt_wrap", 1, 32'hFFFF_FFFC, 0, 32'h500, 1, 32'h500, 1, 32'h0);
      fetch_pc = 32'h140; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h380) begin
         errors++;
         $display("FAIL target_update: %0b %08h expected 1 00000380", pred_taken, pred_target);
      end else $display("ok   target_update");
      fetch_pc = 32'hFFFF_FFFC; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         errors++;
         $display("FAIL fetch_wrap: %0b %08h expected 0 00000000", pred_taken, pred_target);
      end else $display("ok   fetch_wrap");
   endtask

   task automatic test_back_to_back();
      step("b2b_first", 1, 32'h200, 1, 32'h600, 0, 32'h204, 1, 32'h600);
      step("b2b_second", 1, 32'h204, 1, 32'h700, 0, 32'h208, 1, 32'h700);
      step("b2b_end", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h700);
      fetch_pc = 32'h204; #1;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h700) begin
         errors++;
         $display("FAIL b2b_pred: %0b %08h expected 1 00000700", pred_taken, pred_target);
      end else $display("ok   b2b_pred");
      fetch_pc = 32'h140; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
         errors++;
         $display("FAIL b2b_evict: %0b %08h expected 0 00000144", pred_taken, pred_target);
      end else $display("ok   b2b_evict");
   endtask

   task automatic test_same_cycle();
      exp_t e;
      fetch_pc = 32'h208;
      res_valid = 1'b1; res_pc = 32'h208; res_taken = 1'b1; res_target = 32'h800;
      res_pred_taken = 1'b0; res_pred_target = 32'h20C;
      e.rv = 1'b1; e.rpc = 32'h800; e.name = "same_cycle_redirect";
      sb_q.push_back(e);
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h20C) begin
         errors++;
         $display("FAIL same_cycle_pre: %0b %08h expected 0 0000020c", pred_taken, pred_target);
      end else $display("ok   same_cycle_pre");
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h800) begin
         errors++;
         $display("FAIL same_cycle_post: %0b %08h expected 1 00000800", pred_taken, pred_target);
      end else $display("ok   same_cycle_post");
   endtask

   task automatic test_reset_mid();
      step("pre_reset_pulse", 1, 32'h300, 1, 32'h900, 0, 32'h304, 1, 32'h900);
      rst = 1'b1;
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: %0b %08h expected 0 00000000", redirect_valid, redirect_pc);
      end else $display("ok   async_reset");
      // An update presented across an edge while reset is high is discarded.
      res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_target = 32'h200;
      res_pred_taken = 1'b0; res_pred_target = 32'h104;
      @(posedge clk);
      #1;
      rst = 1'b0;
      res_valid = 1'b0;
      fetch_pc = 32'h100; #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104 || redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: %0b %08h rv=%0b expected 0 00000104 rv=0",
                  pred_taken, pred_target, redirect_valid);
      end else $display("ok   reset_discard");
      step("post_reset_idle", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      step("post_reset_alloc", 1, 32'h100, 1, 32'h200, 0, 32'h104, 1, 32'h200);
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_counter();
      test_alias();
      test_redirect();
      test_back_to_back();
      test_same_cycle();
      test_reset_mid();
      @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
